// File: rtl/sipo_rx_if.sv
// Serial-to-parallel receiver bus: serial side, word handshake and status.
// master drives the serial stream and consumer ready; slave is the receiver.
interface sipo_rx_if #(
    parameter int WIDTH = 8
);
    logic             serial_in;
    logic             frame_start;
    logic             bit_en;
    logic             data_ready;
    logic [WIDTH-1:0] parallel_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output serial_in, frame_start, bit_en, data_ready,
        input  parallel_out, data_valid, busy, overrun, parity_err
    );

    modport slave (
        input  serial_in, frame_start, bit_en, data_ready,
        output parallel_out, data_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/sipo_rx.sv
// MSB-first serial-to-parallel receiver with valid/ready output and sticky overrun.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per frame.
module sipo_rx #(
    parameter int WIDTH = 8
) (
    input logic     clk,
    input logic     reset,
    sipo_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_t;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             deliver;
`ifdef SIPO_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // The first bit stays parked in the MSB; later bits shift through the lower WIDTH-1 bits.
    always_comb begin
        shifted = shreg_q;
        for (int i = 1; i < WIDTH - 1; i++) begin
            shifted[i] = shreg_q[i-1];
        end
        shifted[0] = bus.serial_in;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        pout_d    = pout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        deliver   = 1'b0;
`ifdef SIPO_PARITY_EN
        perr_d    = perr_q;
        word      = shreg_q;
`else
        word      = shifted;
`endif

        if (bus.frame_start) begin
            shreg_d            = '0;
            shreg_d[WIDTH-1]   = bus.serial_in;
            cnt_d              = CW'(1);
            state_d            = StShift;
        end else begin
            case (state_q)
                StShift: begin
                    if (bus.bit_en) begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                            state_d = StParity;
`else
                            deliver = 1'b1;
                            state_d = StIdle;
                            cnt_d   = '0;
`endif
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                StParity: begin
                    if (bus.bit_en) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
`endif
                default: ;
            endcase
        end

        if (deliver) begin
            if (!valid_q || bus.data_ready) begin
                pout_d  = word;
                valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                perr_d  = (^shreg_q) ^ bus.serial_in;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shreg_q   <= '0;
            pout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.parallel_out = pout_q;
    assign bus.data_valid   = valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.busy         = (state_q != StIdle);
endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: table-driven frames plus corner sequences; words checked
// against a scoreboard queue when consumed. Honours SIPO_PARITY_EN if defined.
module tb_sipo_rx;
`ifdef SIPO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(8)) bus ();
    sipo_rx #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0] word;
        bit         toggle;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         valid_cnt = 0;
    int         busy_cnt = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_perr(input logic [7:0] w, input logic p);
        return (PAR != 0) ? ((^w) ^ p) : 1'b0;
    endfunction

    task automatic send_frame(input logic [7:0] w, input bit toggle, input logic p);
        bus.frame_start = 1'b1;
        bus.serial_in   = w[7];
        bus.bit_en      = 1'b0;
        step();
        bus.frame_start = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (toggle) begin
                bus.bit_en = 1'b0;
                step();
            end
            bus.bit_en    = 1'b1;
            bus.serial_in = w[i];
            step();
        end
        if (PAR != 0) begin
            if (toggle) begin
                bus.bit_en = 1'b0;
                step();
            end
            bus.bit_en    = 1'b1;
            bus.serial_in = p;
            step();
        end
        bus.bit_en = 1'b0;
    endtask

    // Monitor: count valid/busy cycles and score every consumed word.
    always @(negedge clk) begin
        if (bus.data_valid) valid_cnt++;
        if (bus.busy) busy_cnt++;
        if (bus.data_valid && bus.data_ready && !reset) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected word: got 0x%0h, expected none", bus.parallel_out);
            end else begin
                check("consumed word {perr,data}", {23'd0, bus.parity_err, bus.parallel_out},
                      {23'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        vec_t vecs[7];
        int   v0;
        int   b0;

        vecs[0] = '{8'hAA, 1'b0};
        vecs[1] = '{8'hCC, 1'b1};
        vecs[2] = '{8'h5A, 1'b0};
        vecs[3] = '{8'h01, 1'b1};
        vecs[4] = '{8'h80, 1'b0};
        vecs[5] = '{8'hFF, 1'b0};
        vecs[6] = '{8'h00, 1'b1};

        bus.serial_in   = 1'b0;
        bus.frame_start = 1'b0;
        bus.bit_en      = 1'b0;
        bus.data_ready  = 1'b1;

        #1 reset = 1'b1;
        #2;
        check("reset parallel_out", {24'd0, bus.parallel_out}, 32'h0);
        check("reset data_valid", {31'd0, bus.data_valid}, 32'h0);
        check("reset busy", {31'd0, bus.busy}, 32'h0);
        check("reset overrun", {31'd0, bus.overrun}, 32'h0);
        check("reset parity_err", {31'd0, bus.parity_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // bit_en must be ignored while idle
        bus.bit_en = 1'b1;
        step();
        step();
        bus.bit_en = 1'b0;
        check("idle bit_en busy", {31'd0, bus.busy}, 32'h0);

        for (int k = 0; k < 7; k++) begin
            v0 = valid_cnt;
            b0 = busy_cnt;
            exp_q.push_back({exp_perr(vecs[k].word, ^vecs[k].word), vecs[k].word});
            send_frame(vecs[k].word, vecs[k].toggle, ^vecs[k].word);
            check("valid latency", {31'd0, bus.data_valid}, 32'h1);
            check("frame parallel_out", {24'd0, bus.parallel_out}, {24'd0, vecs[k].word});
            check("frame busy done", {31'd0, bus.busy}, 32'h0);
            step();
            step();
            step();
            check("valid pulse count", valid_cnt - v0, 32'd1);
            check("busy cycles", busy_cnt - b0, (vecs[k].toggle ? 2 : 1) * (7 + PAR));
            check("no overrun", {31'd0, bus.overrun}, 32'h0);
        end

        // Overrun: second word dropped while first is still held
        bus.data_ready = 1'b0;
        exp_q.push_back({exp_perr(8'h11, 1'b0), 8'h11});
        send_frame(8'h11, 1'b0, 1'b0);
        step();
        send_frame(8'h22, 1'b0, 1'b0);
        check("overrun held word", {24'd0, bus.parallel_out}, 32'h11);
        check("overrun set", {31'd0, bus.overrun}, 32'h1);
        check("overrun valid held", {31'd0, bus.data_valid}, 32'h1);
        bus.data_ready = 1'b1;
        step();
        check("consume clears valid", {31'd0, bus.data_valid}, 32'h0);
        check("overrun sticky", {31'd0, bus.overrun}, 32'h1);
        step();
        check("overrun still sticky", {31'd0, bus.overrun}, 32'h1);

        // Reset mid-frame discards 0xF0 and clears sticky flag, independent of clk
        bus.frame_start = 1'b1;
        bus.serial_in   = 1'b1;
        step();
        bus.frame_start = 1'b0;
        bus.bit_en      = 1'b1;
        step();
        bus.serial_in = 1'b1;
        step();
        bus.bit_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async reset busy", {31'd0, bus.busy}, 32'h0);
        check("async reset overrun", {31'd0, bus.overrun}, 32'h0);
        check("async reset parallel_out", {24'd0, bus.parallel_out}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        bus.bit_en = 1'b1;
        step();
        bus.bit_en = 1'b0;
        check("post reset idle", {31'd0, bus.busy}, 32'h0);
        exp_q.push_back({exp_perr(8'h3C, 1'b0), 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b0);
        check("post reset word", {24'd0, bus.parallel_out}, 32'h3C);
        step();

        // Restart after 4 bits of 0xFF, then a full 0x81
        v0 = valid_cnt;
        bus.frame_start = 1'b1;
        bus.serial_in   = 1'b1;
        step();
        bus.frame_start = 1'b0;
        bus.bit_en      = 1'b1;
        step();
        step();
        step();
        bus.bit_en = 1'b0;
        check("partial busy", {31'd0, bus.busy}, 32'h1);
        exp_q.push_back({exp_perr(8'h81, 1'b0), 8'h81});
        send_frame(8'h81, 1'b0, 1'b0);
        check("restart word", {24'd0, bus.parallel_out}, 32'h81);
        step();
        step();
        check("restart single pulse", valid_cnt - v0, 32'd1);
        check("restart no overrun", {31'd0, bus.overrun}, 32'h0);

`ifdef SIPO_PARITY_EN
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b0);
        check("parity good", {31'd0, bus.parity_err}, 32'h0);
        step();
        exp_q.push_back({1'b1, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b1);
        check("parity bad", {31'd0, bus.parity_err}, 32'h1);
        step();
        step();
`endif

        step();
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning the data word length in bits (range 2..32).
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port serial_in  input  1  serial data bit, MSB first, driven by the upstream piso serial_out.
REQ-005 SHALL provide port frame_start  input  1  single-cycle pulse marking that serial_in carries the first (MSB) bit of a frame.
REQ-006 SHALL provide port bit_en  input  1  qualifies serial_in for every bit after the first.
REQ-007 SHALL provide port parallel_out  output  WIDTH  last completed word, registered.
REQ-008 SHALL provide port data_valid  output  1  parallel_out holds an unconsumed word.
REQ-009 SHALL provide port data_ready  input  1  consumer accepts the word when data_valid=1 and data_ready=1 on the same edge.
REQ-010 SHALL provide port busy  output  1  a frame is in progress.
REQ-011 SHALL provide port overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 SHALL provide port parity_err  output  1  parity status of the word in parallel_out.

Function
REQ-013 SHALL implement FSM states IDLE and SHIFT, plus PARITY when SIPO_PARITY_EN is defined.
REQ-014 IDLE: frame_start=1 SHALL sample serial_in into bit WIDTH-1 of the shift register, set bit count to 1, and move to SHIFT; bit_en SHALL be ignored in IDLE.
REQ-015 SHIFT: each edge with bit_en=1 SHALL shift serial_in in at the LSB and increment the count; bit_en=0 SHALL hold all state.
REQ-016 frame_start=1 in SHIFT or PARITY SHALL discard the partial frame and restart per REQ-014, with no flag change.
REQ-017 When the WIDTH-th bit is sampled, the word SHALL be delivered per REQ-018 on that same edge, and the FSM SHALL return to IDLE (or enter PARITY per REQ-027).
REQ-018 Delivery: if data_valid=0, or data_valid=1 with data_ready=1 on that edge, parallel_out SHALL load the word and data_valid SHALL be 1 on the next cycle.
REQ-019 Delivery with data_valid=1 and data_ready=0 SHALL drop the new word, keep parallel_out unchanged, and set overrun=1.
REQ-020 Latency: data_valid SHALL be observed high the cycle after the edge that samples the final bit.
REQ-021 data_valid=1 and data_ready=1 with no delivery on that edge SHALL clear data_valid.
REQ-022 busy SHALL be 1 in SHIFT and PARITY and 0 in IDLE.
REQ-023 overrun SHALL stay 1 until reset.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap mid-frame.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, count=0, shift register=0, parallel_out=0, data_valid=0, busy=0, overrun=0, parity_err=0, independent of clk.
REQ-026 A reset mid-frame SHALL discard the partial frame; the first frame_start after reset deasserts SHALL start a clean frame.

Configuration
REQ-027 With macro SIPO_PARITY_EN defined: after the WIDTH-th data bit, the FSM SHALL enter PARITY, and the next bit_en=1 edge SHALL sample an even-parity bit and perform the delivery; parity_err SHALL load (XOR of data bits and parity bit) together with parallel_out.
REQ-028 Without SIPO_PARITY_EN: the PARITY state SHALL be absent, delivery SHALL occur per REQ-017, and parity_err SHALL be constant 0.

Verification
REQ-029 Frame 0xAA (frame_start with bit 1, then 7 bit_en cycles), data_ready=1 -> parallel_out=0xAA, data_valid high exactly 1 cycle, overrun=0.
REQ-030 Frame 0xCC with bit_en toggling 1/0 every cycle -> parallel_out=0xCC, busy high for 14 cycles.
REQ-031 Frame 0xF0 with reset asserted after 3 bits, then frame 0x3C -> parallel_out=0x3C; 0xF0 is never output.
REQ-032 Frames 0x11 then 0x22 with data_ready=0 -> parallel_out=0x11, overrun=1; data_ready=1 then clears data_valid, and overrun stays 1.
REQ-033 With SIPO_PARITY_EN defined, frame 0xA5 with parity bit 0 -> parity_err=0; repeat with parity bit 1 -> parity_err=1.
REQ-034 frame_start reissued after 4 bits of 0xFF, followed by full frame 0x81 -> parallel_out=0x81, with a single data_valid pulse.
